// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner: one digit slot per CLK_DIV cycles, with a dead time at the start of each slot.
// Loaded data is double-buffered and only reaches the display at a frame boundary. All outputs are registered.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    hex_mode,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [PW:0]   BLANK_END = (PW + 1)'(BLANK_CYCLES);
  localparam logic          SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic          DIG_INV   = (DIG_ACTIVE_LOW != 0);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    hex;
  } disp_t;

  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic          slot_end;
  logic          frame_end;
  disp_t         pend;
  disp_t         disp;
  logic          pend_vld;

  assign slot_end  = (pre == PRE_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (slot_end) begin
      pre <= '0;
      idx <= frame_end ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // A load landing on the wrap cycle stays pending; the commit uses the older pending copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      disp     <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (frame_end && pend_vld) disp <= pend;
      if (load) begin
        pend     <= '{digits: digits, dp: dp_in, blank: blank_in, hex: hex_mode};
        pend_vld <= 1'b1;
      end else if (frame_end) begin
        pend_vld <= 1'b0;
      end
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    if (code > 4'd9 && !hex) s = 7'b0000000;
    return s;
  endfunction

  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    seg_nxt   = '0;
    dp_nxt    = 1'b0;
    sel_nxt   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_code  = disp.digits[4*i +: 4];
        cur_dp    = disp.dp[i];
        cur_blank = disp.blank[i];
      end
    end
    if ({1'b0, pre} >= BLANK_END) begin
      for (int i = 0; i < NUM_DIGITS; i++) sel_nxt[i] = (idx == IW'(i));
      if (!cur_blank) begin
        seg_nxt = decode(cur_code, disp.hex);
        dp_nxt  = cur_dp;
      end
    end
  end

  // Output flops hold pin-level values, so reset drives them straight to the off level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= {7{SEG_INV}};
      dp_out     <= SEG_INV;
      digit_sel  <= {NUM_DIGITS{DIG_INV}};
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt ^ {7{SEG_INV}};
      dp_out     <= dp_nxt ^ SEG_INV;
      digit_sel  <= sel_nxt ^ {NUM_DIGITS{DIG_INV}};
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: an active-high and an active-low instance share one stimulus,
// and every cycle of each frame is compared against hand-computed digit patterns.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        hex_mode = 1'b0;
  logic        load = 1'b0;

  logic [6:0] seg, seg_a;
  logic       dp_out, dp_a;
  logic [3:0] digit_sel, sel_a;
  logic       frame_done, fd_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1),
                    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .blank_in(blank_in),
    .hex_mode(hex_mode), .load(load), .seg(seg), .dp_out(dp_out),
    .digit_sel(digit_sel), .frame_done(frame_done));

  seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1),
                    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_low (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .blank_in(blank_in),
    .hex_mode(hex_mode), .load(load), .seg(seg_a), .dp_out(dp_a),
    .digit_sel(sel_a), .frame_done(fd_a));

  typedef struct {
    logic [15:0]     dig;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            hex;
    logic [3:0][6:0] es;
    logic [3:0]      edp;
  } vec_t;

  vec_t vecs[6];

  // Sample layout: {frame_done, digit_sel, dp_out, seg}
  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Starts right after a frame_done sample; checks the 16 cycles of one frame on both instances.
  task automatic check_frame(input string tag, input logic [3:0][6:0] es, input logic [3:0] edp,
                             input int load_at, input logic [15:0] ld_dig);
    int         j;
    logic       drv, e_dp, e_fd;
    logic [3:0] e_sel;
    logic [6:0] e_seg;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      load  = 1'b0;
      j     = (k - 1) / 4;
      drv   = ((k - 1) % 4) != 0;
      e_sel = drv ? 4'(1 << j) : 4'b0000;
      e_seg = drv ? es[j] : 7'b0000000;
      e_dp  = drv ? edp[j] : 1'b0;
      e_fd  = (k == 16);
      chk($sformatf("%s k=%0d hi", tag, k), {frame_done, digit_sel, dp_out, seg},
          {e_fd, e_sel, e_dp, e_seg});
      chk($sformatf("%s k=%0d lo", tag, k), {fd_a, sel_a, dp_a, seg_a},
          {e_fd, ~e_sel, ~e_dp, ~e_seg});
      if (k == load_at) begin
        digits = ld_dig;
        load   = 1'b1;
      end
    end
  endtask

  logic [3:0][6:0] zeros  = {4{7'b1111110}};
  logic [3:0][6:0] nines  = {4{7'b1111011}};
  logic [3:0][6:0] sevens = {4{7'b1110000}};
  logic [3:0][6:0] prev_es;
  logic [3:0]      prev_dp;

  initial begin
    vecs[0] = '{16'h1234, 4'b0100, 4'b0000, 1'b0,
                {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0100};
    vecs[1] = '{16'hBBBB, 4'b0000, 4'b0000, 1'b0, {4{7'b0000000}}, 4'b0000};
    vecs[2] = '{16'hBBBB, 4'b0000, 4'b0000, 1'b1, {4{7'b0011111}}, 4'b0000};
    vecs[3] = '{16'hFEDC, 4'b1001, 4'b0000, 1'b1,
                {7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110}, 4'b1001};
    vecs[4] = '{16'h8765, 4'b0010, 4'b0010, 1'b0,
                {7'b1111111, 7'b1110000, 7'b0000000, 7'b1011011}, 4'b0000};
    vecs[5] = '{16'h90A0, 4'b1111, 4'b0000, 1'b0,
                {7'b1111011, 7'b1111110, 7'b0000000, 7'b1111110}, 4'b1111};

    // Reset state, then the first frame shows all zeros
    repeat (3) @(negedge clk);
    chk("reset hi", {frame_done, digit_sel, dp_out, seg}, 13'b0);
    chk("reset lo", {fd_a, sel_a, dp_a, seg_a}, {1'b0, 4'b1111, 1'b1, 7'b1111111});
    rst_n = 1'b1;
    check_frame("scan0", zeros, 4'b0000, 0, 16'h0);
    prev_es = zeros;
    prev_dp = 4'b0000;

    // Table: load during a frame, old content holds for that frame, new content the next
    for (int v = 0; v < 6; v++) begin
      digits   = vecs[v].dig;
      dp_in    = vecs[v].dp;
      blank_in = vecs[v].blank;
      hex_mode = vecs[v].hex;
      load     = 1'b1;
      check_frame($sformatf("v%0d old", v), prev_es, prev_dp, 0, 16'h0);
      check_frame($sformatf("v%0d new", v), vecs[v].es, vecs[v].edp, 0, 16'h0);
      prev_es = vecs[v].es;
      prev_dp = vecs[v].edp;
    end

    // Back-to-back loads in one frame: last one wins
    dp_in = 4'b0000; blank_in = 4'b0000; hex_mode = 1'b0;
    digits = 16'h5555;
    load   = 1'b1;
    check_frame("b2b old", prev_es, prev_dp, 8, 16'h9999);
    // Load on the wrap cycle stays pending for one more frame
    check_frame("b2b new", nines, 4'b0000, 15, 16'h7777);
    check_frame("wrap hold", nines, 4'b0000, 0, 16'h0);
    check_frame("wrap new", sevens, 4'b0000, 0, 16'h0);

    // Reset mid-slot with a load pending
    digits = 16'h1234;
    load   = 1'b1;
    repeat (6) @(negedge clk);
    load = 1'b0;
    chk("pre-rst hi", {frame_done, digit_sel, dp_out, seg}, {1'b0, 4'b0010, 1'b0, 7'b1110000});
    #2 rst_n = 1'b0;
    #1;
    chk("async rst hi", {frame_done, digit_sel, dp_out, seg}, 13'b0);
    chk("async rst lo", {fd_a, sel_a, dp_a, seg_a}, {1'b0, 4'b1111, 1'b1, 7'b1111111});
    repeat (2) @(negedge clk);
    chk("held rst hi", {frame_done, digit_sel, dp_out, seg}, 13'b0);
    rst_n = 1'b1;
    check_frame("post-rst", zeros, 4'b0000, 0, 16'h0);
    check_frame("post-rst2", zeros, 4'b0000, 0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
